// File: rtl/l2_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI port to tile L2 between N_REQ requesters.
// The optional per-requester grant/stall counters are built when ARB_PERF_COUNTERS_EN is defined.
module l2_obi_rr_arbiter #(
    parameter int unsigned N_REQ           = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [N_REQ-1:0]                 req_i,
    output logic [N_REQ-1:0]                 gnt_o,
    input  logic [N_REQ-1:0][ADDR_W-1:0]     addr_i,
    input  logic [N_REQ-1:0]                 we_i,
    input  logic [N_REQ-1:0][DATA_W/8-1:0]   be_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]     wdata_i,
    output logic [N_REQ-1:0]                 rvalid_o,
    output logic [N_REQ-1:0][DATA_W-1:0]     rdata_o,
    output logic [N_REQ-1:0]                 err_o,
    output logic                             m_req_o,
    input  logic                             m_gnt_i,
    output logic [ADDR_W-1:0]                m_addr_o,
    output logic                             m_we_o,
    output logic [DATA_W/8-1:0]              m_be_o,
    output logic [DATA_W-1:0]                m_wdata_o,
    input  logic                             m_rvalid_i,
    input  logic [DATA_W-1:0]                m_rdata_i,
    input  logic                             m_err_i,
    output logic                             unexp_rsp_o,
    output logic [N_REQ-1:0][31:0]           perf_gnt_o,
    output logic [N_REQ-1:0][31:0]           perf_stall_o
);

    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] sel_q, sel_rr, sel, head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [SEL_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic             unexp_q;
    logic             full, empty, handshake, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count_q == '0);

    // Highest offset is visited first so the nearest requester at or after rr_ptr wins.
    always_comb begin
        sel_rr = rr_ptr_q;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req_i[(int'(rr_ptr_q) + i) % N_REQ])
                sel_rr = SEL_W'((int'(rr_ptr_q) + i) % N_REQ);
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel     = sel_rr;
        m_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                m_req_o = (|req_i) && !full;
                if (m_req_o && !m_gnt_i) state_d = HOLD;
            end
            HOLD: begin
                sel     = sel_q;
                m_req_o = 1'b1;
                if (m_gnt_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign handshake = m_req_o && m_gnt_i;
    assign rr_ptr_d  = !handshake ? rr_ptr_q
                     : (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + SEL_W'(1);

    assign m_addr_o  = addr_i[sel];
    assign m_we_o    = we_i[sel];
    assign m_be_o    = be_i[sel];
    assign m_wdata_o = wdata_i[sel];

    assign head    = fifo_q[rd_ptr_q];
    assign pop     = m_rvalid_i && !empty;
    assign rdata_o = {N_REQ{m_rdata_i}};

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        err_o    = '0;
        if (handshake) gnt_o[sel] = 1'b1;
        if (pop) begin
            rvalid_o[head] = 1'b1;
            err_o[head]    = m_err_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unexp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (state_q == IDLE) sel_q <= sel_rr;
            if (handshake) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (handshake && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !handshake) count_q <= count_q - CNT_W'(1);
            if (m_rvalid_i && empty) unexp_q <= 1'b1;
        end
    end

    // NOTE: the ID storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (handshake) fifo_q[wr_ptr_q] <= sel;
    end

    assign unexp_rsp_o = unexp_q;

`ifdef ARB_PERF_COUNTERS_EN
    logic [N_REQ-1:0][31:0] perf_gnt_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                if (gnt_o[k])              perf_gnt_q[k]   <= perf_gnt_q[k] + 32'd1;
                if (req_i[k] && !gnt_o[k]) perf_stall_q[k] <= perf_stall_q[k] + 32'd1;
            end
        end
    end

    assign perf_gnt_o   = perf_gnt_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_gnt_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_l2_obi_rr_arbiter.sv
// Self-checking bench for l2_obi_rr_arbiter: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_l2_obi_rr_arbiter;

    localparam int N_REQ   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_OUT = 4;

    logic                           clk_i = 1'b0;
    logic                           rst_ni;
    logic [N_REQ-1:0]               req_i, gnt_o, we_i, rvalid_o, err_o;
    logic [N_REQ-1:0][ADDR_W-1:0]   addr_i;
    logic [N_REQ-1:0][BE_W-1:0]     be_i;
    logic [N_REQ-1:0][DATA_W-1:0]   wdata_i, rdata_o;
    logic                           m_req_o, m_gnt_i, m_we_o, m_rvalid_i, m_err_i, unexp_rsp_o;
    logic [ADDR_W-1:0]              m_addr_o;
    logic [BE_W-1:0]                m_be_o;
    logic [DATA_W-1:0]              m_wdata_o, m_rdata_i;
    logic [N_REQ-1:0][31:0]         perf_gnt_o, perf_stall_o;

    l2_obi_rr_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
        .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i),
        .m_rdata_i(m_rdata_i), .m_err_i(m_err_i), .unexp_rsp_o(unexp_rsp_o),
        .perf_gnt_o(perf_gnt_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requesters in a queue, a pending (un-granted) choice, a rr pointer.
    int               m_rr, m_pend, e_sel;
    int               m_q[$];
    bit               m_unexp, e_mreq, e_pop, found;
    int unsigned      m_pg[N_REQ], m_ps[N_REQ];
    logic [N_REQ-1:0] e_gnt, e_rvalid, e_err;

    always begin : model
        @(negedge clk_i);
        if (!rst_ni) begin
            m_rr = 0; m_pend = -1; m_q.delete(); m_unexp = 0;
            for (int k = 0; k < N_REQ; k++) begin m_pg[k] = 0; m_ps[k] = 0; end
        end
        e_mreq = 0; e_sel = 0; found = 0;
        if (m_pend >= 0) begin
            e_mreq = 1; e_sel = m_pend;
        end else if (req_i != '0 && m_q.size() < MAX_OUT) begin
            for (int i = 0; i < N_REQ; i++)
                if (!found && req_i[(m_rr + i) % N_REQ]) begin
                    found = 1; e_sel = (m_rr + i) % N_REQ;
                end
            e_mreq = 1;
        end
        e_gnt = '0; e_rvalid = '0; e_err = '0;
        if (e_mreq && m_gnt_i) e_gnt[e_sel] = 1'b1;
        e_pop = m_rvalid_i && m_q.size() > 0;
        if (e_pop) begin
            e_rvalid[m_q[0]] = 1'b1;
            e_err[m_q[0]]    = m_err_i;
        end

        check("m_req_o", m_req_o, e_mreq);
        check("gnt_o", gnt_o, e_gnt);
        check("rvalid_o", rvalid_o, e_rvalid);
        check("err_o", err_o, e_err);
        check("unexp_rsp_o", unexp_rsp_o, m_unexp);
        if (e_mreq) begin
            check("m_addr_o", m_addr_o, addr_i[e_sel]);
            check("m_we_o", m_we_o, we_i[e_sel]);
            check("m_be_o", m_be_o, be_i[e_sel]);
            check("m_wdata_o", m_wdata_o, wdata_i[e_sel]);
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (e_rvalid[k]) check("rdata_o", rdata_o[k], m_rdata_i);
`ifdef ARB_PERF_COUNTERS_EN
            check("perf_gnt_o", perf_gnt_o[k], m_pg[k]);
            check("perf_stall_o", perf_stall_o[k], m_ps[k]);
`else
            check("perf_gnt_o", perf_gnt_o[k], 32'd0);
            check("perf_stall_o", perf_stall_o[k], 32'd0);
`endif
        end

        @(posedge clk_i);
        if (rst_ni) begin
            if (e_mreq && m_gnt_i) begin
                m_q.push_back(e_sel); m_rr = (e_sel + 1) % N_REQ; m_pend = -1;
            end else if (e_mreq) begin
                m_pend = e_sel;
            end
            if (e_pop) void'(m_q.pop_front());
            else if (m_rvalid_i) m_unexp = 1;
            for (int k = 0; k < N_REQ; k++) begin
                if (e_gnt[k]) m_pg[k]++;
                if (req_i[k] && !e_gnt[k]) m_ps[k]++;
            end
        end
    end

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [N_REQ-1:0] req, input logic gnt, input logic rv,
                         input logic err, input logic [DATA_W-1:0] rdata);
        req_i = req; m_gnt_i = gnt; m_rvalid_i = rv; m_err_i = err; m_rdata_i = rdata;
    endtask

    task automatic do_reset();
        drive('0, 0, 0, 0, '0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("reset m_req_o", m_req_o, 1'b0);
        check("reset gnt_o", gnt_o, 2'b00);
        check("reset unexp", unexp_rsp_o, 1'b0);
        next();
        rst_ni = 1'b1;
    endtask

    int g0, g1;

    initial begin
        rst_ni = 1'b1;
        drive('0, 0, 0, 0, '0);
        addr_i[0] = 32'h0000_1000; addr_i[1] = 32'h0000_2000;
        we_i = 2'b10;
        be_i[0] = 4'hF; be_i[1] = 4'h3;
        wdata_i[0] = 32'hA0A0_A0A0; wdata_i[1] = 32'hB1B1_B1B1;
        #1 rst_ni = 1'b0;
        next();
        do_reset();

        // 1: single read from requester 0
        drive(2'b01, 1, 0, 0, '0);
        @(negedge clk_i);
        check("t1 gnt", gnt_o, 2'b01);
        check("t1 addr", m_addr_o, 32'h0000_1000);
        check("t1 rvalid1 c0", rvalid_o[1], 1'b0);
        next();
        drive(2'b00, 0, 1, 0, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("t1 rvalid", rvalid_o, 2'b01);
        check("t1 rdata", rdata_o[0], 32'hDEAD_BEEF);
        next();

        // 2: both requesting, slave always grants
        do_reset();
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1, i > 0, 0, DATA_W'(i));
            @(negedge clk_i);
            check("t2 alternation", gnt_o, (i % 2 == 0) ? 64'h1 : 64'h2);
            g0 += int'(gnt_o[0]); g1 += int'(gnt_o[1]);
            next();
        end
        drive(2'b00, 0, 1, 0, 32'h77);
        @(negedge clk_i);
        check("t2 grants req0", g0, 4);
        check("t2 grants req1", g1, 4);
`ifdef ARB_PERF_COUNTERS_EN
        check("t2 perf_gnt0", perf_gnt_o[0], 32'd4);
        check("t2 perf_gnt1", perf_gnt_o[1], 32'd4);
        check("t2 perf_stall0", perf_stall_o[0], 32'd4);
        check("t2 perf_stall1", perf_stall_o[1], 32'd4);
`endif
        next();

        // 3: selection held while the slave stalls
        for (int i = 0; i < 5; i++) begin
            drive((i == 0) ? 2'b01 : (i == 4) ? 2'b10 : 2'b11, i >= 3, 0, 0, '0);
            @(negedge clk_i);
            if (i < 4) check("t3 addr held", m_addr_o, 32'h0000_1000);
            else       check("t3 addr req1", m_addr_o, 32'h0000_2000);
            check("t3 gnt", gnt_o, (i == 3) ? 64'h1 : (i == 4) ? 64'h2 : 64'h0);
            next();
        end
        for (int i = 0; i < 2; i++) begin
            drive(2'b00, 0, 1, 0, DATA_W'(32'h300 + i));
            next();
        end

        // 4: FIFO full with requester 0 streaming
        g0 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, 1, 0, 0, '0);
            @(negedge clk_i);
            g0 += int'(gnt_o[0]);
            if (i >= 4) check("t4 full m_req", m_req_o, 1'b0);
            next();
        end
        check("t4 grant count", g0, 4);
        drive(2'b01, 1, 1, 0, 32'h55);
        @(negedge clk_i);
        check("t4 pop rvalid", rvalid_o, 2'b01);
        check("t4 pop m_req", m_req_o, 1'b0);
        next();
        drive(2'b01, 1, 0, 0, '0);
        @(negedge clk_i);
        check("t4 refill m_req", m_req_o, 1'b1);
        check("t4 refill gnt", gnt_o, 2'b01);
        next();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 0, 1, 0, DATA_W'(32'h400 + i));
            @(negedge clk_i);
            check("t4 drain", rvalid_o, 2'b01);
            next();
        end

        // 5: mixed order routing with an error on the middle response
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1, 0, 0, '0);
            @(negedge clk_i);
            check("t5 gnt order", gnt_o, (i == 1) ? 64'h1 : 64'h2);
            next();
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 0, 1, i == 1, DATA_W'(32'h500 + i));
            @(negedge clk_i);
            check("t5 route", rvalid_o, (i == 1) ? 64'h1 : 64'h2);
            check("t5 err", err_o, (i == 1) ? 64'h1 : 64'h0);
            next();
        end

        // 6: unexpected response, sticky flag, reset mid-operation
        drive(2'b00, 0, 1, 0, 32'h600);
        @(negedge clk_i);
        check("t6 no rvalid", rvalid_o, 2'b00);
        next();
        drive(2'b00, 0, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("t6 unexp sticky", unexp_rsp_o, 1'b1);
            next();
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t6 unexp cleared", unexp_rsp_o, 1'b0);
        next();
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, 1, 0, 0, '0);
            next();
        end
        drive(2'b00, 0, 1, 0, 32'h601);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("t6 rst m_req", m_req_o, 1'b0);
        check("t6 rst gnt", gnt_o, 2'b00);
        check("t6 rst rvalid", rvalid_o, 2'b00);
        check("t6 rst err", err_o, 2'b00);
        next();
        rst_ni = 1'b1;
        drive(2'b00, 0, 1, 0, 32'h602);
        @(negedge clk_i);
        check("t6 forgotten rvalid", rvalid_o, 2'b00);
        next();
        drive(2'b00, 0, 0, 0, '0);
        @(negedge clk_i);
        check("t6 forgotten unexp", unexp_rsp_o, 1'b1);
        next();
        next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
